// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide unit controller: multi-cycle MULT/DIV with a busy window and decode-stage stall.
// Latency: MULT_CYCLES or DIV_CYCLES edges to commit; MTHI/MTLO write on the issuing edge; start is ignored while busy.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use,
  input  logic        rd_sel,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0]   hi_nx, lo_nx;
  logic [31:0]   pend_hi, pend_lo, pend_hi_nx, pend_lo_nx;
  logic          pend_wr, pend_wr_nx;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               div_zero, div_m1;
  logic [31:0]        dvs_s, dvs_u;
  logic signed [31:0] q_s, r_s;
  logic [31:0]        q_u, r_u;
  logic [31:0]        ar_hi, ar_lo;
  logic               ar_wr;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divisors are forced to 1 for b == 0 and signed b == -1 so the dividers never
  // see a zero or the INT_MIN / -1 overflow; those cases are resolved by the muxes below.
  assign div_zero = (b == 32'd0);
  assign div_m1   = &b;
  assign dvs_s    = (div_zero || div_m1) ? 32'd1 : b;
  assign dvs_u    = div_zero ? 32'd1 : b;
  assign q_s      = $signed(a) / $signed(dvs_s);
  assign r_s      = $signed(a) % $signed(dvs_s);
  assign q_u      = a / dvs_u;
  assign r_u      = a % dvs_u;

  always_comb begin
    ar_hi = 32'd0;
    ar_lo = 32'd0;
    ar_wr = 1'b1;
    case (op[1:0])
      2'b00: {ar_hi, ar_lo} = prod_s;
      2'b01: {ar_hi, ar_lo} = prod_u;
      2'b10: begin
        if (div_m1) begin
          ar_hi = 32'd0;
          ar_lo = 32'd0 - a;
        end else begin
          ar_hi = r_s;
          ar_lo = q_s;
        end
        ar_wr = !div_zero;
      end
      default: begin
        ar_hi = r_u;
        ar_lo = q_u;
        ar_wr = !div_zero;
      end
    endcase
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    hi_nx      = hi;
    lo_nx      = lo;
    pend_hi_nx = pend_hi;
    pend_lo_nx = pend_lo;
    pend_wr_nx = pend_wr;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              pend_hi_nx = ar_hi;
              pend_lo_nx = ar_lo;
              pend_wr_nx = ar_wr;
              cnt_nx     = op[1] ? DIV_N : MULT_N;
              state_nx   = RUN;
            end
            3'b100:  hi_nx = a;
            3'b101:  lo_nx = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt <= CW'(1)) begin
          if (pend_wr) begin
            hi_nx = pend_hi;
            lo_nx = pend_lo;
          end
          pend_wr_nx = 1'b0;
          cnt_nx     = '0;
          state_nx   = IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      hi      <= hi_nx;
      lo      <= lo_nx;
      pend_hi <= pend_hi_nx;
      pend_lo <= pend_lo_nx;
      pend_wr <= pend_wr_nx;
    end
  end

  assign busy  = (state == RUN);
  // Stall also covers the issue cycle itself, before busy has risen.
  assign stall = md_use & (busy | (start & (op[2:1] != 2'b11) & (op[2] == 1'b0)));
  assign rdata = rd_sel ? hi : lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO queued at issue, compared when busy falls.
module tb_mdu_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk, reset, start, md_use, rd_sel;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, stall;
  logic [31:0] hi, lo, rdata;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .md_use(md_use), .rd_sel(rd_sel), .busy(busy), .stall(stall),
    .hi(hi), .lo(lo), .rdata(rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
    $fatal(1);
  end

  // Sign/magnitude reference: multiply magnitudes, then fix the sign.
  function automatic logic [63:0] mul_ref(input logic [31:0] x, input logic [31:0] y, input logic sgn);
    logic        nx, ny;
    logic [31:0] ax, ay;
    logic [63:0] p;
    nx = sgn & x[31];
    ny = sgn & y[31];
    ax = nx ? (32'd0 - x) : x;
    ay = ny ? (32'd0 - y) : y;
    p  = {32'd0, ax} * {32'd0, ay};
    if (nx ^ ny) p = 64'd0 - p;
    return p;
  endfunction

  function automatic logic [63:0] div_ref(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn, input logic [63:0] keep);
    logic        nx, ny;
    logic [31:0] ax, ay, q, r;
    if (y == 32'd0) return keep;
    nx = sgn & x[31];
    ny = sgn & y[31];
    ax = nx ? (32'd0 - x) : x;
    ay = ny ? (32'd0 - y) : y;
    q  = ax / ay;
    r  = ax % ay;
    if (nx ^ ny) q = 32'd0 - q;
    if (nx) r = 32'd0 - r;
    return {r, q};
  endfunction

  // Called at a negedge; issues on the next posedge and returns at the following negedge.
  task automatic drive_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    case (o)
      3'd0: begin {m_hi, m_lo} = mul_ref(x, y, 1'b1); exp_q.push_back({m_hi, m_lo}); end
      3'd1: begin {m_hi, m_lo} = mul_ref(x, y, 1'b0); exp_q.push_back({m_hi, m_lo}); end
      3'd2: begin {m_hi, m_lo} = div_ref(x, y, 1'b1, {m_hi, m_lo}); exp_q.push_back({m_hi, m_lo}); end
      3'd3: begin {m_hi, m_lo} = div_ref(x, y, 1'b0, {m_hi, m_lo}); exp_q.push_back({m_hi, m_lo}); end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; md_use = 1'b0; rd_sel = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    #12;
    checks++;
    if ({busy, stall, hi, lo, rdata} !== {2'b00, 96'd0}) begin
      failures++;
      $display("FAIL reset_state busy=%b stall=%b hi=%h lo=%h rdata=%h required all zero", busy, stall, hi, lo, rdata);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mult;
    int n;
    logic [63:0] e;
    drive_op(3'd0, 32'hFFFF_FFFF, 32'd2);
    checks++;
    if ({hi, lo} !== 64'd0) begin
      failures++;
      $display("FAIL mult_pending_hidden hi/lo=%h required 0", {hi, lo});
    end
    wait_idle(n);
    checks++;
    if (n != MULT_N) begin failures++; $display("FAIL mult_busy_cycles got=%0d required=%0d", n, MULT_N); end
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== e || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      failures++;
      $display("FAIL mult_result hi/lo=%h required=%h", {hi, lo}, e);
    end
    drive_op(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== e || {hi, lo} !== 64'h0000_0001_FFFF_FFFE || n != MULT_N) begin
      failures++;
      $display("FAIL multu_result hi/lo=%h cycles=%0d required=%h/%0d", {hi, lo}, n, e, MULT_N);
    end
  endtask

  task automatic test_div;
    int n;
    logic [63:0] e;
    drive_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    checks++;
    if (n != DIV_N) begin failures++; $display("FAIL div_busy_cycles got=%0d required=%0d", n, DIV_N); end
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== e || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      failures++;
      $display("FAIL div_result hi/lo=%h required=%h", {hi, lo}, e);
    end
    drive_op(3'd3, 32'd7, 32'd2);
    wait_idle(n);
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== e || {hi, lo} !== 64'h0000_0001_0000_0003 || n != DIV_N) begin
      failures++;
      $display("FAIL divu_result hi/lo=%h cycles=%0d required=%h/%0d", {hi, lo}, n, e, DIV_N);
    end
  endtask

  task automatic test_div0;
    int n;
    logic [63:0] e;
    drive_op(3'd4, 32'h1234, 32'd0);
    drive_op(3'd5, 32'h5678, 32'd0);
    checks++;
    if ({busy, hi, lo} !== {1'b0, 32'h1234, 32'h5678}) begin
      failures++;
      $display("FAIL mthi_mtlo busy=%b hi=%h lo=%h required 0/1234/5678", busy, hi, lo);
    end
    drive_op(3'd2, 32'd99, 32'd0);
    wait_idle(n);
    checks++;
    if (n != DIV_N) begin failures++; $display("FAIL div0_busy_cycles got=%0d required=%0d", n, DIV_N); end
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== e || {hi, lo} !== {32'h1234, 32'h5678}) begin
      failures++;
      $display("FAIL div0_keep hi/lo=%h required=%h", {hi, lo}, e);
    end
  endtask

  task automatic test_ignore_start;
    int cyc;
    int bad_stall;
    logic [63:0] e;
    md_use = 1'b1;
    drive_op(3'd0, 32'd6, 32'd7);
    cyc = 1;
    bad_stall = 0;
    while (busy === 1'b1 && cyc < 200) begin
      if (stall !== 1'b1) bad_stall++;
      if (cyc == 2) begin start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; end
      else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    md_use = 1'b0;
    checks++;
    if (bad_stall != 0 || cyc - 1 != MULT_N) begin
      failures++;
      $display("FAIL busy_stall low_stall_cycles=%0d busy=%0d required 0/%0d", bad_stall, cyc - 1, MULT_N);
    end
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== e || lo !== 32'd42) begin
      failures++;
      $display("FAIL ignore_start hi/lo=%h required=%h", {hi, lo}, e);
    end
  endtask

  task automatic test_reset_abort;
    int n;
    logic [63:0] e;
    drive_op(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({busy, hi, lo} !== {1'b0, 64'd0}) begin
      failures++;
      $display("FAIL reset_abort busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    end
    exp_q.delete();
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    drive_op(3'd1, 32'd3, 32'd4);
    wait_idle(n);
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== e || lo !== 32'd12 || n != MULT_N) begin
      failures++;
      $display("FAIL post_reset_multu hi/lo=%h cycles=%0d required=%h/%0d", {hi, lo}, n, e, MULT_N);
    end
  endtask

  task automatic test_rdsel;
    int bad;
    logic [31:0] e;
    drive_op(3'd4, 32'hA, 32'd0);
    drive_op(3'd5, 32'hB, 32'd0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      rd_sel = (i % 2 == 1);
      e = rd_sel ? 32'hA : 32'hB;
      #1;
      checks++;
      if (rdata !== e) begin
        failures++;
        $display("FAIL rdata_sel sel=%b rdata=%h required=%h", rd_sel, rdata, e);
      end
      @(negedge clk);
    end
    rd_sel = 1'b0;
  endtask

  task automatic test_stall_issue;
    md_use = 1'b1; start = 1'b1; op = 3'd0;
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL stall_issue_mult stall=%b required=1", stall); end
    op = 3'd6;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL stall_issue_noop stall=%b required=0", stall); end
    op = 3'd3; md_use = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL stall_no_use stall=%b required=0", stall); end
    start = 1'b0; op = 3'd0;
    @(negedge clk);
  endtask

  task automatic test_noop;
    drive_op(3'd6, 32'hFFFF_0000, 32'd1);
    drive_op(3'd7, 32'h1111_2222, 32'd3);
    checks++;
    if ({busy, hi, lo} !== {1'b0, m_hi, m_lo}) begin
      failures++;
      $display("FAIL noop busy=%b hi/lo=%h required 0/%h", busy, {hi, lo}, {m_hi, m_lo});
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [2:0]  o;
    logic [31:0] x, y;
    logic [63:0] e;
    for (int i = 0; i < 12; i++) begin
      o = 3'($urandom_range(0, 5));
      x = $urandom;
      y = (i % 4 == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 100)) : $urandom);
      drive_op(o, x, y);
      if (o < 3'd4) begin
        wait_idle(n);
        e = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== e || n != (o[1] ? DIV_N : MULT_N)) begin
          failures++;
          $display("FAIL b2b op=%0d a=%h b=%h hi/lo=%h cycles=%0d required=%h", o, x, y, {hi, lo}, n, e);
        end
      end else begin
        checks++;
        if ({hi, lo} !== {m_hi, m_lo}) begin
          failures++;
          $display("FAIL b2b_mt op=%0d hi/lo=%h required=%h", o, {hi, lo}, {m_hi, m_lo});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_ignore_start();
    test_reset_abort();
    test_rdsel();
    test_stall_issue();
    test_noop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, SHALL be the busy duration in cycles of MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, SHALL be the busy duration in cycles of DIV/DIVU.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a one-cycle request to issue the operation given by op.
REQ-006 op  input  3  SHALL encode the operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-ops.
REQ-007 a, b  input  32 each  SHALL be the operands (rs, rt); MTHI/MTLO use a only.
REQ-008 md_use  input  1  SHALL flag that the decode-stage instruction uses the MDU (mult/div/mthi/mtlo/mfhi/mflo).
REQ-009 rd_sel  input  1  SHALL select the read result: 0 = LO, 1 = HI.
REQ-010 busy  output  1  SHALL be high while an operation is in flight.
REQ-011 stall  output  1  SHALL request a decode-stage stall.
REQ-012 hi, lo  output  32 each  SHALL be the architectural HI and LO registers.
REQ-013 rdata  output  32  SHALL be rd_sel ? hi : lo, combinational.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-015 In IDLE, start with op 000-011 SHALL latch the result (see REQ-018), load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN on the same edge.
REQ-016 busy SHALL equal (state == RUN); for an op issued at edge T, busy is high for exactly N cycles after T (N = MULT_CYCLES or DIV_CYCLES).
REQ-017 In RUN, the counter SHALL decrement each edge; at the edge where it reaches 1 the block SHALL commit the pending HI/LO and return to IDLE, so the new values are visible when busy falls.
REQ-018 Arithmetic: MULT as signed 32x32->64; MULTU as unsigned; HI = product[63:32], LO = product[31:0]; DIV/DIVU give LO = quotient and HI = remainder (signed: quotient truncated toward zero, remainder sign follows a).
REQ-019 Divide by zero (b == 0): the op SHALL still run the full DIV_CYCLES busy period, and HI/LO SHALL remain unchanged at commit.
REQ-020 MTHI/MTLO in IDLE SHALL write a to HI/LO on the issuing edge, with no busy period.
REQ-021 start SHALL be ignored (no state change, no register write) while in RUN; upstream stall prevents this case in normal operation.
REQ-022 start with op 110/111 SHALL have no effect.
REQ-023 stall SHALL equal md_use & (busy | (start & op[2:1] != 2'b11 & op[2] == 0)), so an MDU instruction entering decode during the issue cycle also stalls.
REQ-024 rdata SHALL reflect the committed hi/lo only; pending results SHALL never be visible before commit.

Reset
REQ-025 When reset is asserted low, the block SHALL asynchronously force state = IDLE, counter = 0, busy = 0, hi = 0, lo = 0, and clear the pending registers.
REQ-026 Reset asserted during RUN SHALL abort the operation; no commit occurs and HI/LO read 0 after reset.
REQ-027 The first edge after reset deasserts SHALL accept start normally.

Verification
REQ-028 MULT with a = 0xFFFFFFFF, b = 2: busy high 5 cycles; then hi = 0xFFFFFFFF, lo = 0xFFFFFFFE. MULTU with the same operands: hi = 0x00000001, lo = 0xFFFFFFFE.
REQ-029 DIV with a = -7 (0xFFFFFFF9), b = 2: busy high 10 cycles; then lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU with a = 7, b = 2: lo = 3, hi = 1.
REQ-030 DIV with b = 0 after MTHI 0x1234 and MTLO 0x5678: busy high 10 cycles; then hi = 0x1234, lo = 0x5678.
REQ-031 Issue MULT, then pulse start with MTLO in busy cycle 2: the MTLO is ignored, and lo equals the MULT result; stall is high whenever md_use = 1 during busy.
REQ-032 Drop reset low in DIV busy cycle 4: busy = 0, hi = lo = 0 immediately; after release, MULTU 3x4 gives lo = 12 after 5 cycles.
REQ-033 With rd_sel toggling each cycle after MTHI 0xA and MTLO 0xB: rdata alternates 0xB/0xA combinationally.
